// File: rtl/adc_conv_ctrl_pkg.sv
// Shared types and constants for the SAR ADC host-side conversion controller.
package adc_conv_ctrl_pkg;

    localparam int unsigned DATA_W_DEF  = 12;
    localparam int unsigned CFG_RST_CYC = 2;

    typedef enum logic [2:0] {
        StCfg,
        StIdle,
        StSample,
        StConv,
        StCapt,
        StGap
    } state_e;

    // Counter width large enough for the longest timed phase.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = CFG_RST_CYC;
        if (a > m) m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module adc_result_fifo #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/adc_conv_ctrl.sv
// Host-side SAR ADC controller: sequences reset/sample/convert, synchronises adc_done and
// streams captured results out of a small FIFO.
module adc_conv_ctrl
    import adc_conv_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SAMPLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              cfg_14b,
    input  logic              start,
    input  logic              cont_en,
    output logic              adc_st_conv,
    output logic              adc_rst,
    output logic              adc_sel_14b,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_result,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              err_timeout,
    output logic [7:0]        ovf_cnt
);

    localparam int unsigned CNT_W = cnt_width(SAMPLE_CYC, TIMEOUT_CYC, GAP_CYC);
    localparam logic [CNT_W-1:0] CFG_LAST     = CNT_W'(CFG_RST_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             done_meta;
    logic             done_sync;
    logic             done_sync_q;
    logic             done_rise;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign done_rise = done_sync & ~done_sync_q;
    assign push      = (state == StCapt);
    assign rd_valid  = ~empty;
    assign pop       = rd_valid & rd_ready;

    always_ff @(posedge clkin) begin
        if (rst) begin
            done_meta   <= 1'b0;
            done_sync   <= 1'b0;
            done_sync_q <= 1'b0;
            ovf_cnt     <= 8'd0;
        end else begin
            done_meta   <= adc_done;
            done_sync   <= done_meta;
            done_sync_q <= done_sync;
            // A full FIFO only drops the sample when nothing leaves in the same cycle.
            if (push && full && !pop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state       <= StCfg;
            cnt         <= '0;
            adc_rst     <= 1'b1;
            adc_st_conv <= 1'b0;
            adc_sel_14b <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            busy <= 1'b1;
            case (state)
                StCfg: begin
                    if (cnt == CFG_LAST) begin
                        state   <= StIdle;
                        adc_rst <= 1'b0;
                        busy    <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StIdle: begin
                    if (cfg_14b != adc_sel_14b) begin
                        state       <= StCfg;
                        adc_rst     <= 1'b1;
                        adc_sel_14b <= cfg_14b;
                        cnt         <= '0;
                    end else if (start || cont_en) begin
                        state       <= StSample;
                        adc_st_conv <= 1'b1;
                        cnt         <= '0;
                        if (start) err_timeout <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StSample: begin
                    if (cnt == SAMPLE_LAST) begin
                        state       <= StConv;
                        adc_st_conv <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StConv: begin
                    if (done_rise) begin
                        state <= StCapt;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        // Lost conversion: re-reset the ADC before trying again.
                        state       <= StCfg;
                        err_timeout <= 1'b1;
                        adc_rst     <= 1'b1;
                        adc_sel_14b <= cfg_14b;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StCapt: begin
                    cnt <= '0;
                    if (!cont_en) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (GAP_CYC == 0) begin
                        state       <= StSample;
                        adc_st_conv <= 1'b1;
                    end else begin
                        state <= StGap;
                    end
                end
                StGap: begin
                    if (!cont_en) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == GAP_LAST) begin
                        state       <= StSample;
                        adc_st_conv <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= StCfg;
                    adc_rst <= 1'b1;
                    cnt     <= '0;
                end
            endcase
        end
    end

    adc_result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clkin),
        .rst       (rst),
        .push      (push),
        .push_data (adc_result),
        .full      (full),
        .pop       (pop),
        .pop_data  (rd_data),
        .empty     (empty)
    );

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Bench for adc_conv_ctrl: ADC behavioural model, transaction-level FIFO/overflow reference
// checked every cycle, directed scenarios followed by a randomized phase.
module tb_adc_conv_ctrl;

    localparam int unsigned SAMPLE_CYC = 8;
    localparam int unsigned DEPTH      = 4;

    logic        clkin = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_14b = 1'b0;
    logic        start = 1'b0;
    logic        cont_en = 1'b0;
    logic        adc_done = 1'b0;
    logic [11:0] adc_result = 12'h000;
    logic        rd_ready = 1'b0;
    logic        adc_st_conv;
    logic        adc_rst;
    logic        adc_sel_14b;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        err_timeout;
    logic [7:0]  ovf_cnt;

    adc_conv_ctrl dut (
        .clkin       (clkin),
        .rst         (rst),
        .cfg_14b     (cfg_14b),
        .start       (start),
        .cont_en     (cont_en),
        .adc_st_conv (adc_st_conv),
        .adc_rst     (adc_rst),
        .adc_sel_14b (adc_sel_14b),
        .adc_done    (adc_done),
        .adc_result  (adc_result),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .ovf_cnt     (ovf_cnt)
    );

    always #5 clkin = ~clkin;

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_wait(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait expired got no event want event", nm);
    endtask

    // ADC model: done drops on st_conv rise, rises t_adc cycles after st_conv falls.
    int          t_adc = 20;
    bit          adc_never = 1'b0;
    bit          rand_tadc = 1'b0;
    bit          use_fixed = 1'b0;
    logic [11:0] fixed_val = 12'h000;
    int          adc_cd = -1;
    logic        st_prev = 1'b0;
    logic [11:0] vals[$];

    initial forever begin
        @(posedge clkin);
        #2;
        if (rst) begin
            adc_done = 1'b0;
            adc_cd   = -1;
            st_prev  = 1'b0;
        end else begin
            if (adc_st_conv && !st_prev) adc_done = 1'b0;
            if (!adc_st_conv && st_prev) begin
                if (rand_tadc) t_adc = $urandom_range(1, 30);
                adc_cd = adc_never ? -1 : t_adc;
            end else if (adc_cd > 0) begin
                adc_cd--;
                if (adc_cd == 0) begin
                    adc_result = use_fixed ? fixed_val : 12'($urandom);
                    vals.push_back(adc_result);
                    adc_done = 1'b1;
                    adc_cd   = -1;
                end
            end
            st_prev = adc_st_conv;
        end
    end

    // Reference: every ADC done edge becomes a push 4 clocks later; queue of DEPTH entries,
    // drop-and-count when full unless the consumer pops in the same cycle.
    logic [11:0] q[$];
    int          pend[$];
    int          ncyc = 0;
    int          movf = 0;
    bit          armed = 1'b0;
    bit          in_rst = 1'b0;
    logic        done_prev = 1'b0;
    int          st_run = 0;
    int          rr_run = 0;

    initial forever begin
        bit pop_m;
        bit push_m;
        bit full_m;
        @(negedge clkin);
        ncyc++;
        if (armed) begin
            check("rd_valid", rd_valid, (q.size() != 0));
            check("rd_data", rd_data, (q.size() != 0) ? q[0] : 12'h000);
            check("ovf_cnt", ovf_cnt, movf);
            if (in_rst) begin
                check("rst_adc_rst", adc_rst, 1);
                check("rst_st_conv", adc_st_conv, 0);
                check("rst_sel", adc_sel_14b, 0);
                check("rst_busy", busy, 0);
                check("rst_err", err_timeout, 0);
            end
            if (rst || adc_st_conv !== 1'b1) begin
                if (!rst && st_run > 0) check("st_conv_width", st_run, SAMPLE_CYC);
                st_run = 0;
            end else begin
                st_run++;
            end
            if (rst) begin
                rr_run = 0;
            end else if (adc_rst === 1'b1) begin
                rr_run++;
            end else if (rr_run > 0) begin
                check("adc_rst_width", rr_run, 2);
                rr_run = 0;
            end
        end
        if (rst) begin
            q.delete();
            pend.delete();
            movf   = 0;
            armed  = 1'b1;
            in_rst = 1'b1;
        end else begin
            in_rst = 1'b0;
            pop_m  = (q.size() != 0) && rd_ready;
            push_m = (pend.size() != 0) && (pend[0] == ncyc);
            if (push_m) void'(pend.pop_front());
            full_m = (q.size() == DEPTH);
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                if (full_m && !pop_m) begin
                    if (movf < 255) movf++;
                end else begin
                    q.push_back(adc_result);
                end
            end
            if (adc_done && !done_prev) pend.push_back(ncyc + 3);
        end
        done_prev = adc_done;
    end

    task automatic pulse_start();
        @(posedge clkin);
        #1 start = 1'b1;
        @(posedge clkin);
        #1 start = 1'b0;
    endtask

    task automatic wait_conv_entry(input string nm);
        bit seen;
        int k;
        seen = 1'b0;
        for (k = 0; k < 500; k++) begin
            @(negedge clkin);
            if (adc_st_conv) seen = 1'b1;
            else if (seen) break;
        end
        if (k == 500) fail_wait(nm);
    endtask

    task automatic wait_vals(input int target, input string nm);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clkin);
            if (vals.size() >= target) break;
        end
        if (k == 3000) fail_wait(nm);
    endtask

    task automatic wait_valid_and_pop(input string nm);
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clkin);
            if (rd_valid) break;
        end
        if (k == 500) fail_wait(nm);
        @(posedge clkin);
        #1 rd_ready = 1'b1;
        @(posedge clkin);
        #1 rd_ready = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        int k;
        logic [11:0] exp_l[4];

        // Reset and release.
        repeat (4) @(posedge clkin);
        #1 rst = 1'b0;
        @(negedge clkin) check("rel_adc_rst_c0", adc_rst, 1);
        @(negedge clkin) check("rel_adc_rst_c1", adc_rst, 1);
        @(negedge clkin) check("rel_adc_rst_c2", adc_rst, 0);
        check("rel_sel", adc_sel_14b, 0);
        check("rel_busy", busy, 0);
        check("rel_rd_valid", rd_valid, 0);

        // Single shot returning 12'hA5C after 20 cycles.
        use_fixed = 1'b1;
        fixed_val = 12'hA5C;
        t_adc     = 20;
        pulse_start();
        n = 1;
        for (k = 0; k < 200; k++) begin
            @(negedge clkin);
            if (n == 1) begin
                check("single_busy", busy, 1);
                check("single_st_conv", adc_st_conv, 1);
            end
            if (rd_valid) break;
            @(posedge clkin);
            n++;
        end
        if (k == 200) fail_wait("single_result");
        check("single_latency", n, 33);
        check("single_data", rd_data, 12'hA5C);
        check("single_valid", rd_valid, 1);
        @(posedge clkin);
        #1 rd_ready = 1'b1;
        @(posedge clkin);
        #1 rd_ready = 1'b0;
        @(negedge clkin);
        check("single_drained", rd_valid, 0);
        check("single_idle", busy, 0);

        // Continuous, consumer stalled: six conversions into four slots.
        use_fixed = 1'b0;
        t_adc     = $urandom_range(5, 15);
        base      = vals.size();
        @(posedge clkin);
        #1 cont_en = 1'b1;
        wait_vals(base + 6, "cont_six");
        @(posedge clkin);
        #1 cont_en = 1'b0;
        repeat (10) @(negedge clkin);
        check("cont_ovf", ovf_cnt, 2);
        check("cont_busy", busy, 0);
        check("cont_head", rd_data, vals[base]);

        // Full FIFO, consumer pops exactly in the capture cycle.
        t_adc = 10;
        pulse_start();
        wait_vals(base + 7, "full_pop_conv");
        @(posedge clkin);
        @(posedge clkin);
        @(posedge clkin);
        #1 rd_ready = 1'b1;
        @(posedge clkin);
        #1 rd_ready = 1'b0;
        @(negedge clkin);
        check("full_pop_ovf", ovf_cnt, 2);
        exp_l[0] = vals[base + 1];
        exp_l[1] = vals[base + 2];
        exp_l[2] = vals[base + 3];
        exp_l[3] = vals[base + 6];
        @(posedge clkin);
        #1 rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clkin);
            check("full_pop_order", rd_data, exp_l[i]);
            @(posedge clkin);
        end
        #1 rd_ready = 1'b0;
        @(negedge clkin);
        check("full_pop_empty", rd_valid, 0);

        // cfg_14b change during CONV is deferred until the capture completes.
        t_adc = 20;
        pulse_start();
        wait_conv_entry("cfg_conv");
        @(posedge clkin);
        #1 cfg_14b = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clkin);
            if (adc_rst) break;
        end
        if (k == 200) fail_wait("cfg_adc_rst");
        check("cfg_captured_first", rd_valid, 1);
        check("cfg_data", rd_data, vals[vals.size() - 1]);
        check("cfg_sel", adc_sel_14b, 1);
        @(negedge clkin) check("cfg_adc_rst_c1", adc_rst, 1);
        @(negedge clkin) check("cfg_adc_rst_c2", adc_rst, 0);
        @(posedge clkin);
        #1 rd_ready = 1'b1;
        @(posedge clkin);
        #1 rd_ready = 1'b0;

        // ADC never answers: timeout after 64 CONV cycles, no push.
        adc_never = 1'b1;
        pulse_start();
        wait_conv_entry("to_conv");
        n = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clkin);
            n++;
            if (err_timeout) break;
        end
        if (k == 200) fail_wait("to_err");
        check("to_cycles", n, 64);
        check("to_adc_rst", adc_rst, 1);
        repeat (5) @(negedge clkin);
        check("to_no_push", rd_valid, 0);
        check("to_sticky", err_timeout, 1);
        adc_never = 1'b0;
        pulse_start();
        @(negedge clkin);
        check("to_cleared", err_timeout, 0);
        wait_valid_and_pop("to_recover");

        // Randomized traffic.
        rand_tadc = 1'b1;
        for (int seg = 0; seg < 5; seg++) begin
            int thr;
            thr = $urandom_range(0, 7);
            for (int c = 0; c < 300; c++) begin
                @(posedge clkin);
                #1;
                rd_ready = ($urandom_range(0, 7) < thr);
                start    = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 63) == 0) cont_en = ~cont_en;
                if ($urandom_range(0, 199) == 0) cfg_14b = ~cfg_14b;
            end
        end
        start    = 1'b0;
        cont_en  = 1'b0;
        rd_ready = 1'b1;
        repeat (150) @(posedge clkin);

        // Reset in the middle of a conversion.
        #1 cont_en = 1'b1;
        wait_conv_entry("mid_rst_conv");
        repeat (3) @(posedge clkin);
        #1 rst = 1'b1;
        repeat (3) @(posedge clkin);
        #1 rst = 1'b0;
        cont_en = 1'b0;
        @(negedge clkin);
        check("mid_rst_adc_rst", adc_rst, 1);
        check("mid_rst_empty", rd_valid, 0);
        repeat (100) @(negedge clkin);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
